// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, functs,
// ALU select codes, mux selects and the FSM state enum.
package mips_pkg;

    localparam int unsigned OP_W     = 6;
    localparam int unsigned FUNC_W   = 6;
    localparam int unsigned ALUSEL_W = 3;
    localparam int unsigned SEL_W    = 2;
    localparam int unsigned STATE_W  = 4;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    localparam logic [FUNC_W-1:0] FN_ADD = 6'h20;
    localparam logic [FUNC_W-1:0] FN_SUB = 6'h22;
    localparam logic [FUNC_W-1:0] FN_AND = 6'h24;
    localparam logic [FUNC_W-1:0] FN_OR  = 6'h25;
    localparam logic [FUNC_W-1:0] FN_SLT = 6'h2A;

    localparam logic [ALUSEL_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALUSEL_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALUSEL_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALUSEL_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALUSEL_W-1:0] ALU_SLT = 3'b111;

    localparam logic [SEL_W-1:0] SRCB_RT  = 2'd0;
    localparam logic [SEL_W-1:0] SRCB_ONE = 2'd1;
    localparam logic [SEL_W-1:0] SRCB_IMM = 2'd2;

    localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'd0;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'd2;

    typedef enum logic [STATE_W-1:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        EXEC_R   = 4'd6,
        R_WB     = 4'd7,
        EXEC_I   = 4'd8,
        I_WB     = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11
    } state_t;

endpackage

// File: rtl/alu_decoder.sv
// Maps an R-type funct field to the ALU operation select; valid_o flags
// functs the datapath supports.
module alu_decoder
    import mips_pkg::*;
(
    input  logic [FUNC_W-1:0]   func_i,
    output logic [ALUSEL_W-1:0] alu_sel_o,
    output logic                valid_o
);

    always_comb begin
        alu_sel_o = ALU_ADD;
        valid_o   = 1'b1;
        case (func_i)
            FN_ADD:  alu_sel_o = ALU_ADD;
            FN_SUB:  alu_sel_o = ALU_SUB;
            FN_AND:  alu_sel_o = ALU_AND;
            FN_OR:   alu_sel_o = ALU_OR;
            FN_SLT:  alu_sel_o = ALU_SLT;
            default: valid_o   = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multicycle MIPS controller: state register plus a Moore output decode,
// with PCEn in BRANCH following the live ALU zero flag.
module control_unit
    import mips_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [OP_W-1:0]     opcode,
    input  logic [FUNC_W-1:0]   func,
    input  logic                zero,
    output logic                PCEn,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                MemtoReg,
    output logic                IRWrite,
    output logic                RegWrite,
    output logic                RegDst,
    output logic                ALUSrcA,
    output logic [SEL_W-1:0]    PCSource,
    output logic [SEL_W-1:0]    ALUSrcB,
    output logic [ALUSEL_W-1:0] ALUSel,
    output logic                instr_done,
    output logic                illegal,
    output logic [STATE_W-1:0]  state_o
);

    state_t                state_q, state_d;
    logic                  is_load_q, is_load_d;
    logic [ALUSEL_W-1:0]   fn_alu_sel;
    logic                  fn_valid;

    alu_decoder u_alu_decoder (
        .func_i    (func),
        .alu_sel_o (fn_alu_sel),
        .valid_o   (fn_valid)
    );

    // lw/sw choice is captured in DECODE so MEM_ADDR does not re-read the IR
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            is_load_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_load_q <= is_load_d;
        end
    end

    assign state_o = rst ? STATE_W'(FETCH) : STATE_W'(state_q);

    always_comb begin
        state_d    = state_q;
        is_load_d  = is_load_q;
        PCEn       = 1'b0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        MemtoReg   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        RegDst     = 1'b0;
        ALUSrcA    = 1'b0;
        PCSource   = PCSRC_ALU;
        ALUSrcB    = SRCB_RT;
        ALUSel     = ALU_AND;
        instr_done = 1'b0;
        illegal    = 1'b0;

        case (state_q)
            FETCH: begin
                MemRead  = 1'b1;
                IRWrite  = 1'b1;
                ALUSrcB  = SRCB_ONE;
                ALUSel   = ALU_ADD;
                PCSource = PCSRC_ALU;
                PCEn     = 1'b1;
                state_d  = DECODE;
            end
            DECODE: begin
                ALUSrcB = SRCB_IMM;
                ALUSel  = ALU_ADD;
                case (opcode)
                    OP_LW: begin
                        state_d   = MEM_ADDR;
                        is_load_d = 1'b1;
                    end
                    OP_SW: begin
                        state_d   = MEM_ADDR;
                        is_load_d = 1'b0;
                    end
                    OP_RTYPE: begin
                        if (fn_valid) begin
                            state_d = EXEC_R;
                        end else begin
                            state_d = FETCH;
                            illegal = 1'b1;
                        end
                    end
                    OP_ADDI: state_d = EXEC_I;
                    OP_BEQ:  state_d = BRANCH;
                    OP_J:    state_d = JUMP;
                    default: begin
                        state_d = FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ALUSel  = ALU_ADD;
                state_d = is_load_q ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                state_d = MEM_WB;
            end
            MEM_WB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            MEM_WR: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_RT;
                ALUSel  = fn_alu_sel;
                state_d = R_WB;
            end
            R_WB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ALUSel  = ALU_ADD;
                state_d = I_WB;
            end
            I_WB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_RT;
                ALUSel     = ALU_SUB;
                PCSource   = PCSRC_ALUOUT;
                PCEn       = zero;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            JUMP: begin
                PCSource   = PCSRC_JUMP;
                PCEn       = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            default: state_d = FETCH;
        endcase

        // Reset silences every strobe in the same cycle it is asserted
        if (rst) begin
            state_d    = FETCH;
            is_load_d  = 1'b0;
            PCEn       = 1'b0;
            IorD       = 1'b0;
            MemRead    = 1'b0;
            MemWrite   = 1'b0;
            MemtoReg   = 1'b0;
            IRWrite    = 1'b0;
            RegWrite   = 1'b0;
            RegDst     = 1'b0;
            ALUSrcA    = 1'b0;
            PCSource   = PCSRC_ALU;
            ALUSrcB    = SRCB_RT;
            ALUSel     = ALU_AND;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: each cycle's expected control word is
// queued as stimulus is applied and popped/compared mid-cycle.
module tb_control_unit;

    typedef struct packed {
        logic [3:0] st;
        logic       pcen, iord, memrd, memwr, mtr, irw, regw, regdst, srca;
        logic [1:0] srcb;
        logic [1:0] pcsrc;
        logic [2:0] alu;
        logic       done, ill;
    } ctl_t;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADDR = 4'd2,
                           S_MEM_RD = 4'd3, S_MEM_WB = 4'd4, S_MEM_WR = 4'd5,
                           S_EXEC_R = 4'd6, S_R_WB = 4'd7, S_EXEC_I = 4'd8,
                           S_I_WB = 4'd9, S_BRANCH = 4'd10, S_JUMP = 4'd11;

    localparam logic [2:0] A_AND = 3'b000, A_OR = 3'b001, A_ADD = 3'b010,
                           A_SUB = 3'b110, A_SLT = 3'b111;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode, func;
    logic       zero;
    logic       PCEn, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegWrite, RegDst, ALUSrcA;
    logic [1:0] PCSource, ALUSrcB;
    logic [2:0] ALUSel;
    logic       instr_done, illegal;
    logic [3:0] state_o;

    int         checks_cnt = 0;
    int         pass_cnt   = 0;
    ctl_t       exp_q[$];
    string      tag_q[$];

    control_unit dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero),
        .PCEn(PCEn), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemtoReg(MemtoReg), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .RegDst(RegDst), .ALUSrcA(ALUSrcA), .PCSource(PCSource),
        .ALUSrcB(ALUSrcB), .ALUSel(ALUSel), .instr_done(instr_done),
        .illegal(illegal), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Expected control word for a state, straight from the state table
    function automatic ctl_t exp_ctl(input logic [3:0] st, input logic z,
                                     input logic [2:0] alu, input logic ill);
        ctl_t c;
        c    = '0;
        c.st = st;
        case (st)
            S_FETCH:    begin c.memrd = 1; c.irw = 1; c.srcb = 2'd1; c.alu = A_ADD; c.pcen = 1; end
            S_DECODE:   begin c.srcb = 2'd2; c.alu = A_ADD; c.ill = ill; end
            S_MEM_ADDR: begin c.srca = 1; c.srcb = 2'd2; c.alu = A_ADD; end
            S_MEM_RD:   begin c.memrd = 1; c.iord = 1; end
            S_MEM_WB:   begin c.regw = 1; c.mtr = 1; c.done = 1; end
            S_MEM_WR:   begin c.memwr = 1; c.iord = 1; c.done = 1; end
            S_EXEC_R:   begin c.srca = 1; c.srcb = 2'd0; c.alu = alu; end
            S_R_WB:     begin c.regw = 1; c.regdst = 1; c.done = 1; end
            S_EXEC_I:   begin c.srca = 1; c.srcb = 2'd2; c.alu = A_ADD; end
            S_I_WB:     begin c.regw = 1; c.done = 1; end
            S_BRANCH:   begin c.srca = 1; c.alu = A_SUB; c.pcsrc = 2'd1; c.pcen = z; c.done = 1; end
            S_JUMP:     begin c.pcsrc = 2'd2; c.pcen = 1; c.done = 1; end
            default:    c = '0;
        endcase
        return c;
    endfunction

    task automatic check_pop();
        ctl_t  e;
        ctl_t  o;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        o = {state_o, PCEn, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegWrite,
             RegDst, ALUSrcA, ALUSrcB, PCSource, ALUSel, instr_done, illegal};
        checks_cnt++;
        assert (o === e) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", t, o, e);
    endtask

    // Apply one cycle of inputs, queue its expectation, compare, advance
    task automatic step(input string tag, input logic r, input logic [5:0] op,
                        input logic [5:0] fn, input logic z, input ctl_t e);
        rst    = r;
        opcode = op;
        func   = fn;
        zero   = z;
        tag_q.push_back(tag);
        exp_q.push_back(e);
        #2;
        check_pop();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; opcode = 6'h23; func = 6'h00; zero = 1'b0;
        #1;

        for (int i = 0; i < 3; i++) step("reset", 1, 6'h23, 6'h00, 0, '0);

        step("lw_fetch",   0, 6'h23, 6'h00, 0, exp_ctl(S_FETCH,    0, 0, 0));
        step("lw_decode",  0, 6'h23, 6'h00, 0, exp_ctl(S_DECODE,   0, 0, 0));
        step("lw_addr",    0, 6'h23, 6'h00, 0, exp_ctl(S_MEM_ADDR, 0, 0, 0));
        step("lw_rd",      0, 6'h23, 6'h00, 0, exp_ctl(S_MEM_RD,   0, 0, 0));
        step("lw_wb",      0, 6'h23, 6'h00, 0, exp_ctl(S_MEM_WB,   0, 0, 0));

        step("sub_fetch",  0, 6'h00, 6'h22, 0, exp_ctl(S_FETCH,  0, 0, 0));
        step("sub_decode", 0, 6'h00, 6'h22, 0, exp_ctl(S_DECODE, 0, 0, 0));
        step("sub_exec",   0, 6'h00, 6'h22, 0, exp_ctl(S_EXEC_R, 0, A_SUB, 0));
        step("sub_wb",     0, 6'h00, 6'h22, 0, exp_ctl(S_R_WB,   0, 0, 0));

        step("or_fetch",   0, 6'h00, 6'h25, 0, exp_ctl(S_FETCH,  0, 0, 0));
        step("or_decode",  0, 6'h00, 6'h25, 0, exp_ctl(S_DECODE, 0, 0, 0));
        step("or_exec",    0, 6'h00, 6'h25, 0, exp_ctl(S_EXEC_R, 0, A_OR, 0));
        step("or_wb",      0, 6'h00, 6'h25, 0, exp_ctl(S_R_WB,   0, 0, 0));

        step("slt_fetch",  0, 6'h00, 6'h2A, 0, exp_ctl(S_FETCH,  0, 0, 0));
        step("slt_decode", 0, 6'h00, 6'h2A, 0, exp_ctl(S_DECODE, 0, 0, 0));
        step("slt_exec",   0, 6'h00, 6'h2A, 0, exp_ctl(S_EXEC_R, 0, A_SLT, 0));
        step("slt_wb",     0, 6'h00, 6'h2A, 0, exp_ctl(S_R_WB,   0, 0, 0));

        step("and_fetch",  0, 6'h00, 6'h24, 0, exp_ctl(S_FETCH,  0, 0, 0));
        step("and_decode", 0, 6'h00, 6'h24, 0, exp_ctl(S_DECODE, 0, 0, 0));
        step("and_exec",   0, 6'h00, 6'h24, 0, exp_ctl(S_EXEC_R, 0, A_AND, 0));
        step("and_wb",     0, 6'h00, 6'h24, 0, exp_ctl(S_R_WB,   0, 0, 0));

        step("sw_fetch",   0, 6'h2B, 6'h00, 0, exp_ctl(S_FETCH,    0, 0, 0));
        step("sw_decode",  0, 6'h2B, 6'h00, 0, exp_ctl(S_DECODE,   0, 0, 0));
        step("sw_addr",    0, 6'h2B, 6'h00, 0, exp_ctl(S_MEM_ADDR, 0, 0, 0));
        step("sw_wr",      0, 6'h2B, 6'h00, 0, exp_ctl(S_MEM_WR,   0, 0, 0));

        step("addi_fetch", 0, 6'h08, 6'h00, 0, exp_ctl(S_FETCH,  0, 0, 0));
        step("addi_dec",   0, 6'h08, 6'h00, 0, exp_ctl(S_DECODE, 0, 0, 0));
        step("addi_exec",  0, 6'h08, 6'h00, 0, exp_ctl(S_EXEC_I, 0, 0, 0));
        step("addi_wb",    0, 6'h08, 6'h00, 0, exp_ctl(S_I_WB,   0, 0, 0));

        step("beqt_fetch", 0, 6'h04, 6'h00, 0, exp_ctl(S_FETCH,  0, 0, 0));
        step("beqt_dec",   0, 6'h04, 6'h00, 0, exp_ctl(S_DECODE, 0, 0, 0));
        step("beqt_br",    0, 6'h04, 6'h00, 1, exp_ctl(S_BRANCH, 1, 0, 0));
        step("beqn_fetch", 0, 6'h04, 6'h00, 1, exp_ctl(S_FETCH,  0, 0, 0));
        step("beqn_dec",   0, 6'h04, 6'h00, 1, exp_ctl(S_DECODE, 0, 0, 0));
        step("beqn_br",    0, 6'h04, 6'h00, 0, exp_ctl(S_BRANCH, 0, 0, 0));

        step("j_fetch",    0, 6'h02, 6'h00, 0, exp_ctl(S_FETCH,  0, 0, 0));
        step("j_decode",   0, 6'h02, 6'h00, 0, exp_ctl(S_DECODE, 0, 0, 0));
        step("j_jump",     0, 6'h02, 6'h00, 0, exp_ctl(S_JUMP,   0, 0, 0));

        step("ill_op_fetch", 0, 6'h3F, 6'h00, 0, exp_ctl(S_FETCH,  0, 0, 0));
        step("ill_op_dec",   0, 6'h3F, 6'h00, 0, exp_ctl(S_DECODE, 0, 0, 1));
        step("ill_fn_fetch", 0, 6'h00, 6'h01, 0, exp_ctl(S_FETCH,  0, 0, 0));
        step("ill_fn_dec",   0, 6'h00, 6'h01, 0, exp_ctl(S_DECODE, 0, 0, 1));

        step("rsw_fetch",  0, 6'h2B, 6'h00, 0, exp_ctl(S_FETCH,  0, 0, 0));
        step("rsw_decode", 0, 6'h2B, 6'h00, 0, exp_ctl(S_DECODE, 0, 0, 0));
        step("rsw_addr",   1, 6'h2B, 6'h00, 0, '0);
        step("rsw_hold",   1, 6'h2B, 6'h00, 0, '0);
        step("rsw_after",  0, 6'h2B, 6'h00, 0, exp_ctl(S_FETCH,  0, 0, 0));
        step("rsw_decode2",0, 6'h2B, 6'h00, 0, exp_ctl(S_DECODE, 0, 0, 0));

        $display("%0d/%0d checks passed", pass_cnt, checks_cnt);
        $finish;
    end

endmodule
